// File: rtl/opti_sos_mc_if.sv
// Stream, clear and result signals of the time-multiplexed biquad.
// The master drives the sample stream and receives results; the slave is the filter.
interface opti_sos_mc_if #(
    parameter int DW  = 24,
    parameter int CHW = 2
) ();
    logic           in_valid;
    logic           in_ready;
    logic [CHW-1:0] in_ch;
    logic [DW-1:0]  in_data;
    logic           bypass;
    logic           clr_ch_valid;
    logic [CHW-1:0] clr_ch;
    logic           out_valid;
    logic [CHW-1:0] out_ch;
    logic [DW-1:0]  out_data;
    logic           out_sat;

    modport master (
        output in_valid, in_ch, in_data, bypass, clr_ch_valid, clr_ch,
        input  in_ready, out_valid, out_ch, out_data, out_sat
    );

    modport slave (
        input  in_valid, in_ch, in_data, bypass, clr_ch_valid, clr_ch,
        output in_ready, out_valid, out_ch, out_data, out_sat
    );
endinterface

// File: rtl/opti_sos_mc.sv
// Direct Form I biquad shared by NCH channels through one pipelined multiplier set.
// A channel stays busy from accept until its result writes back its history.
module opti_sos_mc #(
    parameter int DW        = 24,
    parameter int CW        = 24,
    parameter int FRAC      = 22,
    parameter int NCH       = 4,
    parameter int CHW       = 2,
    parameter int MULT_PIPE = 3
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic [CW-1:0] b0,
    input  logic [CW-1:0] b1,
    input  logic [CW-1:0] b2,
    input  logic [CW-1:0] a1,
    input  logic [CW-1:0] a2,
    opti_sos_mc_if.slave  bus
);
    localparam int SW = DW + 3;
    localparam int PW = DW + CW;
    localparam logic signed [SW-1:0] SUM_MAX = {{(SW-DW+1){1'b0}}, {(DW-1){1'b1}}};
    localparam logic signed [SW-1:0] SUM_MIN = {{(SW-DW+1){1'b1}}, {(DW-1){1'b0}}};
    localparam logic [DW-1:0]        Y_MAX   = {1'b0, {(DW-1){1'b1}}};
    localparam logic [DW-1:0]        Y_MIN   = {1'b1, {(DW-1){1'b0}}};

    typedef struct packed {
        logic           vld;
        logic [CHW-1:0] ch;
        logic           byp;
        logic [DW-1:0]  x;
        logic [DW-1:0]  x1;
        logic [DW-1:0]  x2;
        logic [DW-1:0]  y1;
        logic [DW-1:0]  y2;
    } op_t;

    typedef struct packed {
        logic           vld;
        logic [CHW-1:0] ch;
        logic           byp;
        logic [DW-1:0]  x;
        logic [DW-1:0]  x1;
        logic [DW-1:0]  y1;
        logic [SW-1:0]  t0;
        logic [SW-1:0]  t1;
        logic [SW-1:0]  t2;
        logic [SW-1:0]  t3;
        logic [SW-1:0]  t4;
    } mp_t;

    // Full-precision signed product, floor-truncated back to the data format.
    function automatic logic [SW-1:0] mul_q(input logic [CW-1:0] c, input logic [DW-1:0] d);
        logic signed [PW-1:0] p;
        p = PW'($signed(c)) * PW'($signed(d));
        return SW'(p >>> FRAC);
    endfunction

    logic [DW-1:0]  x1_q [NCH];
    logic [DW-1:0]  x2_q [NCH];
    logic [DW-1:0]  y1_q [NCH];
    logic [DW-1:0]  y2_q [NCH];
    logic [DW-1:0]  x1_d [NCH];
    logic [DW-1:0]  x2_d [NCH];
    logic [DW-1:0]  y1_d [NCH];
    logic [DW-1:0]  y2_d [NCH];
    logic [NCH-1:0] busy_q, busy_d;
    op_t            op_q, op_d;
    mp_t            mp_q [MULT_PIPE];
    mp_t            mp_d [MULT_PIPE];
    logic           out_valid_q, out_valid_d;
    logic [CHW-1:0] out_ch_q, out_ch_d;
    logic [DW-1:0]  out_data_q, out_data_d;
    logic           out_sat_q, out_sat_d;

    logic           rdy_s;
    logic           accept_s;
    logic [DW-1:0]  rd_x1_s, rd_x2_s, rd_y1_s, rd_y2_s;
    mp_t            last_s;
    logic signed [SW-1:0] sum_s;
    logic [DW-1:0]  ysat_s;
    logic           sat_s;
    logic           wb_upd_s;

    // Channel lookup: readiness and history operands of in_ch; out-of-range channels never ready.
    always_comb begin
        rdy_s   = 1'b0;
        rd_x1_s = '0;
        rd_x2_s = '0;
        rd_y1_s = '0;
        rd_y2_s = '0;
        for (int i = 0; i < NCH; i++) begin
            if (bus.in_ch == CHW'(i)) begin
                rdy_s   = !busy_q[i];
                rd_x1_s = x1_q[i];
                rd_x2_s = x2_q[i];
                rd_y1_s = y1_q[i];
                rd_y2_s = y2_q[i];
            end else begin
                rdy_s   = rdy_s;
            end
        end
    end

    assign accept_s     = bus.in_valid & rdy_s;
    assign bus.in_ready = rdy_s;

    // Operand capture and multiplier pipeline advance.
    always_comb begin
        op_d = '{vld: accept_s, ch: bus.in_ch, byp: bus.bypass, x: bus.in_data,
                 x1: rd_x1_s, x2: rd_x2_s, y1: rd_y1_s, y2: rd_y2_s};
        mp_d[0] = '{vld: op_q.vld, ch: op_q.ch, byp: op_q.byp,
                    x: op_q.x, x1: op_q.x1, y1: op_q.y1,
                    t0: mul_q(b0, op_q.x),  t1: mul_q(b1, op_q.x1),
                    t2: mul_q(b2, op_q.x2), t3: mul_q(a1, op_q.y1),
                    t4: mul_q(a2, op_q.y2)};
        for (int k = 1; k < MULT_PIPE; k++) begin
            mp_d[k] = mp_q[k-1];
        end
    end

    assign last_s   = mp_q[MULT_PIPE-1];
    assign wb_upd_s = last_s.vld & !last_s.byp;

    // Five-term sum with clipping to the data range.
    always_comb begin
        sum_s = $signed(last_s.t0) + $signed(last_s.t1) + $signed(last_s.t2)
              - $signed(last_s.t3) - $signed(last_s.t4);
        if (sum_s > SUM_MAX) begin
            ysat_s = Y_MAX;
            sat_s  = 1'b1;
        end else if (sum_s < SUM_MIN) begin
            ysat_s = Y_MIN;
            sat_s  = 1'b1;
        end else begin
            ysat_s = sum_s[DW-1:0];
            sat_s  = 1'b0;
        end
    end

    // Output register: bypass samples pass x through unclipped.
    always_comb begin
        out_valid_d = last_s.vld;
        out_ch_d    = out_ch_q;
        out_data_d  = out_data_q;
        out_sat_d   = out_sat_q;
        if (last_s.vld) begin
            out_ch_d   = last_s.ch;
            out_data_d = last_s.byp ? last_s.x : ysat_s;
            out_sat_d  = last_s.byp ? 1'b0 : sat_s;
        end else begin
            out_sat_d  = out_sat_q;
        end
    end

    // History writeback and busy tracking; a clear beats a same-edge writeback.
    always_comb begin
        busy_d = busy_q;
        for (int i = 0; i < NCH; i++) begin
            x1_d[i] = x1_q[i];
            x2_d[i] = x2_q[i];
            y1_d[i] = y1_q[i];
            y2_d[i] = y2_q[i];
            if (bus.clr_ch_valid && (bus.clr_ch == CHW'(i))) begin
                x1_d[i] = '0;
                x2_d[i] = '0;
                y1_d[i] = '0;
                y2_d[i] = '0;
            end else if (wb_upd_s && (last_s.ch == CHW'(i))) begin
                x2_d[i] = last_s.x1;
                x1_d[i] = last_s.x;
                y2_d[i] = last_s.y1;
                y1_d[i] = ysat_s;
            end else begin
                x1_d[i] = x1_q[i];
            end
            if (last_s.vld && (last_s.ch == CHW'(i))) begin
                busy_d[i] = 1'b0;
            end else begin
                busy_d[i] = busy_d[i];
            end
            if (accept_s && (bus.in_ch == CHW'(i))) begin
                busy_d[i] = 1'b1;
            end else begin
                busy_d[i] = busy_d[i];
            end
        end
    end

    // State, pipeline and output registers; reset discards samples in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            x1_q        <= '{default: '0};
            x2_q        <= '{default: '0};
            y1_q        <= '{default: '0};
            y2_q        <= '{default: '0};
            busy_q      <= '0;
            op_q        <= '0;
            mp_q        <= '{default: '0};
            out_valid_q <= 1'b0;
            out_ch_q    <= '0;
            out_data_q  <= '0;
            out_sat_q   <= 1'b0;
        end else begin
            x1_q        <= x1_d;
            x2_q        <= x2_d;
            y1_q        <= y1_d;
            y2_q        <= y2_d;
            busy_q      <= busy_d;
            op_q        <= op_d;
            mp_q        <= mp_d;
            out_valid_q <= out_valid_d;
            out_ch_q    <= out_ch_d;
            out_data_q  <= out_data_d;
            out_sat_q   <= out_sat_d;
        end
    end

    assign bus.out_valid = out_valid_q;
    assign bus.out_ch    = out_ch_q;
    assign bus.out_data  = out_data_q;
    assign bus.out_sat   = out_sat_q;
endmodule
